// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-enable definitions for the pipelined ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   localparam logic [2:0] EN_ZVN  = 3'b111;
   localparam logic [2:0] EN_Z    = 3'b100;
   localparam logic [2:0] EN_NONE = 3'b000;

   function automatic logic [2:0] flag_en_of(input logic [3:0] op);
      logic [2:0] en;
      case (op)
         OP_ADD, OP_SUB:                            en = EN_ZVN;
         OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR,
         OP_PADDSB:                                 en = EN_Z;
         default:                                   en = EN_NONE;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue-side and writeback-side handshake bundle of the pipelined ALU.
interface alu_pipe_if #(parameter int WIDTH = 16) ();
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [2:0]       out_flag_en;
   logic [2:0]       flags;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_flag_en, flags
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_flag_en, flags
   );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, pending {Z,V,N} and the flag-enable mask.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int LANE       = 4,
   parameter bit SAT_ADDSUB = 1'b1
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic [2:0]       zvn_o,
   output logic [2:0]       flag_en_o
);

   localparam int SHW = $clog2(WIDTH);
   localparam int NB  = WIDTH / 8;
   localparam int NL  = WIDTH / LANE;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
   localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

   logic [WIDTH-1:0]   sum, diff, red, padd, sll, sra, ror;
   logic [WIDTH-1:0]   add_res, sub_res;
   logic [2*WIDTH-1:0] rot2;
   logic [SHW-1:0]     shamt;
   logic               add_ov, sub_ov;
   logic [LANE-1:0]    la, lb, ls;

   always_comb begin
      sum    = a_i + b_i;
      diff   = a_i - b_i;
      add_ov = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1]  != a_i[WIDTH-1]);
      sub_ov = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      // Overflow direction is always the sign of A for both ADD and SUB.
      add_res = (SAT_ADDSUB && add_ov) ? (a_i[WIDTH-1] ? SMIN : SMAX) : sum;
      sub_res = (SAT_ADDSUB && sub_ov) ? (a_i[WIDTH-1] ? SMIN : SMAX) : diff;

      red = '0;
      for (int i = 0; i < NB; i++) begin
         red = red + {{(WIDTH-8){a_i[i*8+7]}}, a_i[i*8 +: 8]}
                   + {{(WIDTH-8){b_i[i*8+7]}}, b_i[i*8 +: 8]};
      end

      padd = '0;
      la   = '0;
      lb   = '0;
      ls   = '0;
      for (int j = 0; j < NL; j++) begin
         la = a_i[j*LANE +: LANE];
         lb = b_i[j*LANE +: LANE];
         ls = la + lb;
         if ((la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]))
            padd[j*LANE +: LANE] = la[LANE-1] ? LMIN : LMAX;
         else
            padd[j*LANE +: LANE] = ls;
      end

      shamt = b_i[SHW-1:0];
      sll   = a_i << shamt;
      sra   = $unsigned($signed(a_i) >>> shamt);
      rot2  = {a_i, a_i} >> shamt;
      ror   = rot2[WIDTH-1:0];

      case (op_i)
         OP_ADD:        result_o = add_res;
         OP_SUB:        result_o = sub_res;
         OP_XOR:        result_o = a_i ^ b_i;
         OP_RED:        result_o = red;
         OP_SLL:        result_o = sll;
         OP_SRA:        result_o = sra;
         OP_ROR:        result_o = ror;
         OP_PADDSB:     result_o = padd;
         OP_LW, OP_SW:  result_o = sum;
         OP_LLB:        result_o = {a_i[WIDTH-1:WIDTH/2], b_i[WIDTH/2-1:0]};
         OP_LHB:        result_o = {b_i[WIDTH/2-1:0], a_i[WIDTH/2-1:0]};
         default:       result_o = a_i | b_i;
      endcase

      zvn_o         = '0;
      zvn_o[FLAG_Z] = (result_o == '0);
      zvn_o[FLAG_V] = (op_i == OP_ADD) ? add_ov : ((op_i == OP_SUB) ? sub_ov : 1'b0);
      zvn_o[FLAG_N] = result_o[WIDTH-1];
      flag_en_o     = flag_en_of(op_i);
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline; owns the architectural ZVN flag register.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int LANE       = 4,
   parameter bit SAT_ADDSUB = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   alu_pipe_if.slave  bus
);

   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic [2:0]       s2_en_q, s2_en_d, s2_zvn_q, s2_zvn_d;
   logic [2:0]       flags_q, flags_d;

   logic [WIDTH-1:0] core_result;
   logic [2:0]       core_zvn, core_en;
   logic             s2_adv, in_rdy, commit;

   alu_core #(.WIDTH(WIDTH), .LANE(LANE), .SAT_ADDSUB(SAT_ADDSUB)) u_core (
      .op_i      (s1_op_q),
      .a_i       (s1_a_q),
      .b_i       (s1_b_q),
      .result_o  (core_result),
      .zvn_o     (core_zvn),
      .flag_en_o (core_en)
   );

   assign s2_adv = !s2_valid_q || bus.out_ready;
   assign in_rdy = !s1_valid_q || s2_adv;
   assign commit = s2_valid_q && bus.out_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_en_d     = s2_en_q;
      s2_zvn_d    = s2_zvn_q;

      if (in_rdy) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_op_d = bus.in_op;
            s1_a_d  = bus.in_a;
            s1_b_d  = bus.in_b;
         end
      end

      // Result registers only load on a real transfer so they hold under backpressure.
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_result_d = core_result;
            s2_en_d     = core_en;
            s2_zvn_d    = core_zvn;
         end
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end

      flags_d = commit ? ((flags_q & ~s2_en_q) | (s2_zvn_q & s2_en_q)) : flags_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_en_q     <= '0;
         s2_zvn_q    <= '0;
         flags_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_en_q     <= s2_en_d;
         s2_zvn_q    <= s2_zvn_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.in_ready    = in_rdy;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_result  = s2_result_q;
   assign bus.out_flag_en = s2_en_q;
   assign bus.flags       = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  en;
      logic [2:0]  zvn;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];
   logic [2:0] mflags = 3'b000;
   logic acc;

   alu_pipe_if #(.WIDTH(16)) bus ();

   alu_pipe #(.WIDTH(16), .LANE(4), .SAT_ADDSUB(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   sa, sb, s, r, ln;
      logic v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      v  = 1'b0;
      r  = 0;
      case (op)
         4'd0: begin s = sa + sb; v = (s > 32767) || (s < -32768); r = clamp(s, -32768, 32767); end
         4'd1: begin s = sa - sb; v = (s > 32767) || (s < -32768); r = clamp(s, -32768, 32767); end
         4'd2: r = int'(a ^ b);
         4'd3: r = int'($signed(a[7:0])) + int'($signed(a[15:8]))
                 + int'($signed(b[7:0])) + int'($signed(b[15:8]));
         4'd4: r = int'(a) << b[3:0];
         4'd5: r = sa >>> b[3:0];
         4'd6: r = (int'(a) >> b[3:0]) | (int'(a) << (16 - int'(b[3:0])));
         4'd7: for (int k = 0; k < 4; k++) begin
                  ln = clamp(int'($signed(a[4*k +: 4])) + int'($signed(b[4*k +: 4])), -8, 7);
                  r  = r | ((ln & 15) << (4*k));
               end
         4'd8, 4'd9: r = int'(a) + int'(b);
         4'd10: r = int'({a[15:8], b[7:0]});
         4'd11: r = int'({b[7:0], a[7:0]});
         default: r = int'(a | b);
      endcase
      e.res = r[15:0];
      e.en  = (op <= 4'd1) ? 3'b111 : ((op <= 4'd7) ? 3'b100 : 3'b000);
      e.zvn = {(e.res == 16'h0), v, e.res[15]};
      return e;
   endfunction

   task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ordy, input logic fl, output logic accepted);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = ordy;
      flush         = fl;
      #1;
      accepted = v && bus.in_ready;
      if (bus.out_valid) begin
         if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
         else begin
            chk("result", 32'(bus.out_result), 32'(q[0].res));
            chk("flag_en", 32'(bus.out_flag_en), 32'(q[0].en));
            if (ordy) begin
               e      = q.pop_front();
               mflags = (mflags & ~e.en) | (e.zvn & e.en);
            end
         end
      end
      if (fl) q.delete();
      else if (accepted) q.push_back(model(op, a, b));
      @(posedge clk);
      #1;
      chk("flags", 32'(bus.flags), 32'(mflags));
      bus.in_valid = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic idle(input logic ordy);
      logic a;
      step(1'b0, 4'd0, 16'h0, 16'h0, ordy, 1'b0, a);
   endtask

   task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) step(1'b1, op, a, b, 1'b1, 1'b0, got);
      if (!got) chk("send_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'd0;
      bus.in_a      = 16'h0;
      bus.in_b      = 16'h0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_result", 32'(bus.out_result), 32'd0);
      chk("rst_flag_en", 32'(bus.out_flag_en), 32'd0);
      chk("rst_flags", 32'(bus.flags), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Saturating ADD, latency two edges after accept
      step(1'b1, 4'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, acc);
      chk("add_accept", 32'(acc), 32'd1);
      idle(1'b1);
      chk("add_latency", 32'(bus.out_valid), 32'd1);
      chk("add_result", 32'(bus.out_result), 32'h7FFF);
      chk("add_flag_en", 32'(bus.out_flag_en), 32'h7);
      idle(1'b1);
      chk("add_flags", 32'(bus.flags), 32'h2);

      step(1'b1, 4'd1, 16'h0005, 16'h0005, 1'b1, 1'b0, acc);
      step(1'b1, 4'd2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, acc);
      idle(1'b1);
      chk("sub_flags", 32'(bus.flags), 32'h4);
      idle(1'b1);
      chk("xor_flags", 32'(bus.flags), 32'h4);

      step(1'b1, 4'd7, 16'h7777, 16'h1111, 1'b1, 1'b0, acc);
      idle(1'b1);
      chk("paddsb_result", 32'(bus.out_result), 32'h7777);
      idle(1'b1);
      chk("paddsb_flags", 32'(bus.flags), 32'h0);

      // Backpressure: two accepted, then stall
      step(1'b1, 4'd0, 16'h0001, 16'h0002, 1'b0, 1'b0, acc);
      step(1'b1, 4'd1, 16'h000A, 16'h0003, 1'b0, 1'b0, acc);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step(1'b1, 4'd2, 16'h00F0, 16'h0F0F, 1'b0, 1'b0, acc);
      chk("bp_accept3", 32'(acc), 32'd0);
      send(4'd2, 16'h00F0, 16'h0F0F);
      send(4'd4, 16'h0003, 16'h0004);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("bp_drain", 32'(q.size()), 32'd0);

      // Flush with both stages full
      step(1'b1, 4'd1, 16'h8000, 16'h0001, 1'b0, 1'b0, acc);
      step(1'b1, 4'd0, 16'h4000, 16'h4000, 1'b0, 1'b0, acc);
      step(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      step(1'b1, 4'd0, 16'h0003, 16'h0004, 1'b1, 1'b0, acc);
      idle(1'b1);
      chk("post_flush_valid", 32'(bus.out_valid), 32'd1);
      chk("post_flush_result", 32'(bus.out_result), 32'h7);
      idle(1'b1);

      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), acc);
      end
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("rand_drain", 32'(q.size()), 32'd0);

      // Asynchronous reset mid-stream
      send(4'd0, 16'h7FFF, 16'h0001);
      idle(1'b1);
      idle(1'b1);
      step(1'b1, 4'd2, 16'h1234, 16'h4321, 1'b0, 1'b0, acc);
      step(1'b1, 4'd3, 16'h8080, 16'h7F01, 1'b0, 1'b0, acc);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_flags", 32'(bus.flags), 32'd0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      q.delete();
      mflags = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 4'd6, 16'h8001, 16'h0001, 1'b1, 1'b0, acc);
      idle(1'b1);
      chk("ror_valid", 32'(bus.out_valid), 32'd1);
      chk("ror_result", 32'(bus.out_result), 32'hC000);
      idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
